// File: rtl/ulas_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM states and
// small decode helpers used by the top level and the iterative unit.
package ulas_pkg;

  // Operation codes carried on aluop.
  localparam logic [4:0] OP_ADD = 5'b00001;
  localparam logic [4:0] OP_SUB = 5'b00010;
  localparam logic [4:0] OP_AND = 5'b00011;
  localparam logic [4:0] OP_OR  = 5'b00100;
  localparam logic [4:0] OP_NOT = 5'b00101;
  localparam logic [4:0] OP_XOR = 5'b00110;
  localparam logic [4:0] OP_SLL = 5'b00111;
  localparam logic [4:0] OP_SRL = 5'b01000;
  localparam logic [4:0] OP_LT  = 5'b01001;
  localparam logic [4:0] OP_GT  = 5'b01010;
  localparam logic [4:0] OP_EQ  = 5'b01011;
  localparam logic [4:0] OP_NE  = 5'b01100;
  localparam logic [4:0] OP_LE  = 5'b01101;
  localparam logic [4:0] OP_GE  = 5'b01110;
  localparam logic [4:0] OP_LUI = 5'b01111;
  localparam logic [4:0] OP_MUL = 5'b10000;
  localparam logic [4:0] OP_DIV = 5'b10001;
  localparam logic [4:0] OP_REM = 5'b10010;

  // Mode select for the iterative multiply/divide unit.
  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  // Control FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  // True for the two opcodes served by the restoring divider.
  function automatic logic is_divide(input logic [4:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  // True for opcodes that need the iterative unit at all.
  function automatic logic is_iterative(input logic [4:0] op);
    return (op == OP_MUL) || is_divide(op);
  endfunction

endpackage

// File: rtl/ulas_iter_muldiv.sv
// Iterative shift-add multiplier and restoring divider, one bit per cycle.
// The first iteration is folded into the start cycle so that the result is
// ready (done pulse) WIDTH-1 cycles after start.
module ulas_iter_muldiv
  import ulas_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);
  // Counter value at which the final iteration is being performed.
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 2);

  logic             busy_r;
  logic             done_r;
  logic [CW-1:0]    cnt_r;
  logic             mode_r;

  // Multiply state: accumulator, shifted multiplicand, shifted multiplier.
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;

  // Divide state: partial remainder (one guard bit), dividend/quotient, divisor.
  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvsr_r;

  // Sources of the current iteration: fresh operands on start, else registers.
  logic             step_mul_s;
  logic [WIDTH-1:0] src_acc_s;
  logic [WIDTH-1:0] src_mcand_s;
  logic [WIDTH-1:0] src_mplier_s;
  logic [WIDTH:0]   src_rem_s;
  logic [WIDTH-1:0] src_quo_s;
  logic [WIDTH-1:0] src_dvsr_s;

  // Results of one iteration.
  logic [WIDTH-1:0] acc_nxt_s;
  logic [WIDTH-1:0] mcand_nxt_s;
  logic [WIDTH-1:0] mplier_nxt_s;
  logic [WIDTH:0]   rem_shift_s;
  logic [WIDTH:0]   rem_diff_s;
  logic [WIDTH:0]   rem_nxt_s;
  logic [WIDTH-1:0] quo_nxt_s;

  // Select iteration inputs: start cycle seeds from the operand ports.
  always_comb begin
    if (start) begin
      step_mul_s   = (mode == MODE_MUL);
      src_acc_s    = '0;
      src_mcand_s  = a;
      src_mplier_s = b;
      src_rem_s    = '0;
      src_quo_s    = a;
      src_dvsr_s   = b;
    end else begin
      step_mul_s   = (mode_r == MODE_MUL);
      src_acc_s    = acc_r;
      src_mcand_s  = mcand_r;
      src_mplier_s = mplier_r;
      src_rem_s    = rem_r;
      src_quo_s    = quo_r;
      src_dvsr_s   = dvsr_r;
    end
  end

  // One shift-add step: add the multiplicand when the multiplier LSB is set.
  always_comb begin
    if (src_mplier_s[0]) begin
      acc_nxt_s = src_acc_s + src_mcand_s;
    end else begin
      acc_nxt_s = src_acc_s;
    end
    mcand_nxt_s  = src_mcand_s << 1;
    mplier_nxt_s = src_mplier_s >> 1;
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_shift_s = {src_rem_s[WIDTH-1:0], src_quo_s[WIDTH-1]};
    rem_diff_s  = rem_shift_s - {1'b0, src_dvsr_s};
    if (rem_diff_s[WIDTH] == 1'b0) begin
      rem_nxt_s = rem_diff_s;
      quo_nxt_s = {src_quo_s[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt_s = rem_shift_s;
      quo_nxt_s = {src_quo_s[WIDTH-2:0], 1'b0};
    end
  end

  // Iteration control and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      cnt_r    <= '0;
      mode_r   <= MODE_MUL;
      acc_r    <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
      rem_r    <= '0;
      quo_r    <= '0;
      dvsr_r   <= '0;
    end else if (start || busy_r) begin
      if (start) begin
        busy_r <= 1'b1;
        done_r <= 1'b0;
        cnt_r  <= '0;
        mode_r <= mode;
        dvsr_r <= b;
      end else begin
        cnt_r <= cnt_r + CW'(1);
        if (cnt_r == LAST_CNT) begin
          busy_r <= 1'b0;
          done_r <= 1'b1;
        end else begin
          done_r <= 1'b0;
        end
      end
      if (step_mul_s) begin
        acc_r    <= acc_nxt_s;
        mcand_r  <= mcand_nxt_s;
        mplier_r <= mplier_nxt_s;
      end else begin
        rem_r <= rem_nxt_s;
        quo_r <= quo_nxt_s;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign done       = done_r;
  assign product_lo = acc_r;
  assign quotient   = quo_r;
  assign remainder  = rem_r[WIDTH-1:0];

endmodule

// File: rtl/ulas_mc.sv
// Multi-cycle ALU with valid/ready handshakes on operands and results.
// Operands are captured on accept and decoded one cycle later, so every
// result (single-cycle or iterative) lands in registered outputs.
module ulas_mc
  import ulas_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [SHW-1:0]   smt,
  input  logic [4:0]       aluop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r1,
  output logic             uf
);

  state_e           state_r;
  logic             go_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] r1_r;
  logic             uf_r;

  logic [WIDTH-1:0] op1_r;
  logic [WIDTH-1:0] op2_r;
  logic [SHW-1:0]   smt_r;
  logic [4:0]       aluop_r;

  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] dif_s;
  logic [WIDTH-1:0] alu_r1_s;
  logic             alu_uf_s;
  logic             div_zero_s;
  logic             start_s;
  logic             mode_s;

  logic             md_done_s;
  logic [WIDTH-1:0] md_prod_s;
  logic [WIDTH-1:0] md_quo_s;
  logic [WIDTH-1:0] md_rem_s;

  assign sum_s      = op1_r + op2_r;
  assign dif_s      = op1_r - op2_r;
  assign div_zero_s = (op2_r == '0);
  assign mode_s     = (aluop_r == OP_MUL) ? MODE_MUL : MODE_DIV;
  // Launch the iterative unit in the decode cycle, unless dividing by zero.
  assign start_s    = (state_r == IDLE) && go_r &&
                      ((aluop_r == OP_MUL) || (is_divide(aluop_r) && !div_zero_s));

  ulas_iter_muldiv #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_s),
    .mode       (mode_s),
    .a          (op1_r),
    .b          (op2_r),
    .done       (md_done_s),
    .product_lo (md_prod_s),
    .quotient   (md_quo_s),
    .remainder  (md_rem_s)
  );

  // Single-cycle datapath and flag rules on the captured operands.
  always_comb begin
    alu_r1_s = '0;
    alu_uf_s = 1'b0;
    case (aluop_r)
      OP_ADD: begin
        alu_r1_s = sum_s;
        alu_uf_s = (op1_r[WIDTH-1] == op2_r[WIDTH-1]) && (sum_s[WIDTH-1] != op1_r[WIDTH-1]);
      end
      OP_SUB: begin
        alu_r1_s = dif_s;
        alu_uf_s = (op1_r[WIDTH-1] != op2_r[WIDTH-1]) && (dif_s[WIDTH-1] != op1_r[WIDTH-1]);
      end
      OP_AND:  alu_r1_s = op1_r & op2_r;
      OP_OR:   alu_r1_s = op1_r | op2_r;
      OP_NOT:  alu_r1_s = ~op1_r;
      OP_XOR:  alu_r1_s = op1_r ^ op2_r;
      OP_SLL:  alu_r1_s = op1_r << smt_r;
      OP_SRL:  alu_r1_s = op1_r >> smt_r;
      OP_LT:   alu_uf_s = (op1_r <  op2_r);
      OP_GT:   alu_uf_s = (op1_r >  op2_r);
      OP_EQ:   alu_uf_s = (op1_r == op2_r);
      OP_NE:   alu_uf_s = (op1_r != op2_r);
      OP_LE:   alu_uf_s = (op1_r <= op2_r);
      OP_GE:   alu_uf_s = (op1_r >= op2_r);
      OP_LUI:  alu_r1_s = op2_r << (WIDTH / 2);
      default: alu_r1_s = op2_r;
    endcase
  end

  // Control FSM with operand capture and registered handshake/result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      go_r        <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      r1_r        <= '0;
      uf_r        <= 1'b0;
      op1_r       <= '0;
      op2_r       <= '0;
      smt_r       <= '0;
      aluop_r     <= 5'b00000;
    end else begin
      case (state_r)
        IDLE: begin
          if (go_r) begin
            // Decode cycle for the bundle captured on the previous edge.
            go_r <= 1'b0;
            if (aluop_r == OP_MUL) begin
              state_r <= MUL;
            end else if (is_divide(aluop_r)) begin
              if (div_zero_s) begin
                r1_r        <= (aluop_r == OP_DIV) ? {WIDTH{1'b1}} : op1_r;
                uf_r        <= 1'b1;
                out_valid_r <= 1'b1;
                state_r     <= DONE;
              end else begin
                state_r <= DIV;
              end
            end else begin
              r1_r        <= alu_r1_s;
              uf_r        <= alu_uf_s;
              out_valid_r <= 1'b1;
              state_r     <= DONE;
            end
          end else if (in_valid && in_ready_r) begin
            op1_r      <= op1;
            op2_r      <= op2;
            smt_r      <= smt;
            aluop_r    <= aluop;
            go_r       <= 1'b1;
            in_ready_r <= 1'b0;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        MUL: begin
          if (md_done_s) begin
            r1_r        <= md_prod_s;
            uf_r        <= 1'b0;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            state_r <= MUL;
          end
        end
        DIV: begin
          if (md_done_s) begin
            r1_r        <= (aluop_r == OP_DIV) ? md_quo_s : md_rem_s;
            uf_r        <= 1'b0;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            state_r <= DIV;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          go_r        <= 1'b0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign r1        = r1_r;
  assign uf        = uf_r;

endmodule
